// File: rtl/msrv32_machine_control.sv
// -----------------------------------------------------------------------------
// msrv32_machine_control
//
// Trap and privilege sequencer for the msrv32 RV32I machine-mode core.
// Turns the decoder's fault flags, the fetch misalignment flag and the CSR
// interrupt state into the PC source select, pipeline flush and CSR strobes.
//
// Handshake note: this block has no valid/ready pairs. Every request input is
// a level sampled on each rising clock edge while in OPERATING. Each strobe
// output is a single-cycle pulse that is valid for exactly the cycle it is
// high.
//
// Ports
//   ms_riscv32_mp_clk_in     core clock, rising edge
//   ms_riscv32_mp_rst_n_in   asynchronous, active-low reset
//   illegal_instr_in, misaligned_load_in, misaligned_store_in,
//   misaligned_instr_in      exception flags from decoder / fetch
//   opcode_6_to_2_in, funct3_in, funct7_in,
//   rs1_addr_in, rs2_addr_in, rd_addr_in
//                            instruction fields used for SYSTEM decode
//   mie_in                   mstatus.MIE
//   meie_in/mtie_in/msie_in  mie enable bits
//   meip_in/mtip_in/msip_in  mip pending bits
//   pc_src_out               00 BOOT, 01 EPC, 10 TRAP, 11 NEXT
//   trap_taken_out           trap in progress (decoder and CSR file)
//   flush_out                kill the instruction in the pipeline register
//   set_epc_out, set_cause_out  mepc / mcause write strobes
//   cause_out, i_or_e_out    mcause code and interrupt flag (held)
//   mie_clear_out, mie_set_out  mstatus.MIE update strobes
//   instret_inc_out          retire pulse for minstret
//   misaligned_exception_out trap is a misalignment (cause 0, 4, 6)
// -----------------------------------------------------------------------------
module msrv32_machine_control (
    input  logic       ms_riscv32_mp_clk_in,
    input  logic       ms_riscv32_mp_rst_n_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       misaligned_instr_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic [1:0] pc_src_out,
    output logic       trap_taken_out,
    output logic       flush_out,
    output logic       set_epc_out,
    output logic       set_cause_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out,
    output logic       misaligned_exception_out
);

    typedef enum logic [1:0] {
        S_RESET       = 2'd0,
        S_OPERATING   = 2'd1,
        S_TRAP_TAKEN  = 2'd2,
        S_TRAP_RETURN = 2'd3
    } state_t;

    state_t     r_state;
    logic [1:0] r_pc_src;
    logic       r_trap_taken;
    logic       r_flush;
    logic       r_set_epc;
    logic       r_set_cause;
    logic       r_mie_clear;
    logic       r_mie_set;
    logic [3:0] r_cause;
    logic       r_i_or_e;
    logic       r_mis;

    logic       w_system;
    logic       w_ecall;
    logic       w_ebreak;
    logic       w_mret;
    logic       w_exc;
    logic       w_irq;
    logic       w_trap;
    logic [3:0] w_exc_cause;
    logic [3:0] w_irq_cause;
    logic       w_exc_mis;

    // SYSTEM with funct3 = 0 and rs1 = rd = 0; WFI and others fall through as NOP.
    assign w_system = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'd0) &&
                      (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    assign w_ecall  = w_system && (funct7_in == 7'd0) && (rs2_addr_in == 5'd0);
    assign w_ebreak = w_system && (funct7_in == 7'd0) && (rs2_addr_in == 5'd1);
    assign w_mret   = w_system && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'd2);

    assign w_exc  = illegal_instr_in | misaligned_instr_in | misaligned_load_in |
                    misaligned_store_in | w_ecall | w_ebreak;
    assign w_irq  = mie_in & ((meie_in & meip_in) | (msie_in & msip_in) |
                              (mtie_in & mtip_in));
    assign w_trap = w_exc | w_irq;

    always_comb begin
        w_exc_cause = 4'd0;
        if (misaligned_instr_in)      w_exc_cause = 4'd0;
        else if (illegal_instr_in)    w_exc_cause = 4'd2;
        else if (w_ebreak)            w_exc_cause = 4'd3;
        else if (w_ecall)             w_exc_cause = 4'd11;
        else if (misaligned_load_in)  w_exc_cause = 4'd4;
        else if (misaligned_store_in) w_exc_cause = 4'd6;
    end

    always_comb begin
        w_irq_cause = 4'd7;
        if (meie_in & meip_in)      w_irq_cause = 4'd11;
        else if (msie_in & msip_in) w_irq_cause = 4'd3;
    end

    assign w_exc_mis = (w_exc_cause == 4'd0) || (w_exc_cause == 4'd4) ||
                       (w_exc_cause == 4'd6);

    // Outputs are registered alongside the state: each branch loads the
    // output values belonging to the state being entered. Anything that is
    // not OPERATING returns to OPERATING, so those are the default values.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            r_state      <= S_RESET;
            r_pc_src     <= 2'b00;
            r_flush      <= 1'b1;
            r_trap_taken <= 1'b0;
            r_set_epc    <= 1'b0;
            r_set_cause  <= 1'b0;
            r_mie_clear  <= 1'b0;
            r_mie_set    <= 1'b0;
            r_cause      <= 4'd0;
            r_i_or_e     <= 1'b0;
            r_mis        <= 1'b0;
        end else begin
            r_state      <= S_OPERATING;
            r_pc_src     <= 2'b11;
            r_flush      <= 1'b0;
            r_trap_taken <= 1'b0;
            r_set_epc    <= 1'b0;
            r_set_cause  <= 1'b0;
            r_mie_clear  <= 1'b0;
            r_mie_set    <= 1'b0;
            if (r_state == S_OPERATING) begin
                if (w_trap) begin
                    r_state      <= S_TRAP_TAKEN;
                    r_pc_src     <= 2'b10;
                    r_flush      <= 1'b1;
                    r_trap_taken <= 1'b1;
                    r_set_epc    <= 1'b1;
                    r_set_cause  <= 1'b1;
                    r_mie_clear  <= 1'b1;
                    // Exceptions take precedence over interrupts.
                    r_cause      <= w_exc ? w_exc_cause : w_irq_cause;
                    r_i_or_e     <= ~w_exc;
                    r_mis        <= w_exc & w_exc_mis;
                end else if (w_mret) begin
                    r_state      <= S_TRAP_RETURN;
                    r_pc_src     <= 2'b01;
                    r_flush      <= 1'b1;
                    r_mie_set    <= 1'b1;
                end
            end
        end
    end

    assign pc_src_out               = r_pc_src;
    assign trap_taken_out           = r_trap_taken;
    assign flush_out                = r_flush;
    assign set_epc_out              = r_set_epc;
    assign set_cause_out            = r_set_cause;
    assign mie_clear_out            = r_mie_clear;
    assign mie_set_out              = r_mie_set;
    assign cause_out                = r_cause;
    assign i_or_e_out               = r_i_or_e;
    assign misaligned_exception_out = r_mis;
    // Retire only an instruction that neither traps nor returns.
    assign instret_inc_out = (r_state == S_OPERATING) & ~w_trap & ~w_mret;

endmodule

// File: doc/msrv32_machine_control.md
# msrv32_machine_control

Trap and privilege sequencer for the msrv32 RV32I machine-mode core. Consumes the decoder's exception flags (illegal instruction, misaligned load/store), the fetch misalignment flag and the CSR interrupt state, and drives the decoder's `trap_taken_in`, the PC source select, pipeline flush and CSR update strobes. It closes the loop opened by the decoder: the decoder reports faults, this block acts on them.

## Interface
- No parameters.
- `ms_riscv32_mp_clk_in`  in  1  core clock, rising edge
- `ms_riscv32_mp_rst_n_in`  in  1  asynchronous, active-low reset
- `illegal_instr_in`  in  1  from decoder `illegal_instr_out`
- `misaligned_load_in`  in  1  from decoder `misaligned_load_out`
- `misaligned_store_in`  in  1  from decoder `misaligned_store_out`
- `misaligned_instr_in`  in  1  fetch target not 4-byte aligned
- `opcode_6_to_2_in`  in  5  current instruction `opcode[6:2]`
- `funct3_in`  in  3  instruction `[14:12]`
- `funct7_in`  in  7  instruction `[31:25]`
- `rs1_addr_in`, `rs2_addr_in`, `rd_addr_in`  in  5 each  instruction register fields
- `mie_in`  in  1  `mstatus.MIE`
- `meie_in`, `mtie_in`, `msie_in`  in  1 each  `mie` enable bits
- `meip_in`, `mtip_in`, `msip_in`  in  1 each  `mip` pending bits
- `pc_src_out`  out  2  `00` BOOT, `01` EPC, `10` TRAP, `11` NEXT
- `trap_taken_out`  out  1  to decoder `trap_taken_in` and CSR file
- `flush_out`  out  1  kill the instruction in the pipeline register
- `set_epc_out`, `set_cause_out`  out  1 each  CSR write strobes for `mepc` and `mcause`
- `cause_out`  out  4  `mcause` code
- `i_or_e_out`  out  1  `mcause[31]`: 1 interrupt, 0 exception
- `mie_clear_out`, `mie_set_out`  out  1 each  `mstatus.MIE` update strobes
- `instret_inc_out`  out  1  retire pulse for `minstret`
- `misaligned_exception_out`  out  1  trap is a misalignment (cause 0, 4, 6)

## Operation
- Decode: SYSTEM = `opcode_6_to_2_in == 5'b11100`, `funct3 == 0`, `rs1 == 0`, `rd == 0`. ECALL: `funct7 == 0`, `rs2 == 0`. EBREAK: `funct7 == 0`, `rs2 == 1`. MRET: `funct7 == 7'b0011000`, `rs2 == 2`. WFI and any other SYSTEM/funct3=0 encoding are treated as NOP.
- Exception request `exc` is the OR of illegal, misaligned instr/load/store, ECALL and EBREAK.
- Exception cause priority, highest first: misaligned instr 0, illegal 2, EBREAK 3, ECALL 11, misaligned load 4, misaligned store 6.
- Interrupt request `irq = mie_in & ((meie&meip)|(msie&msip)|(mtie&mtip))`. Interrupt cause priority: external 11, software 3, timer 7.
- Exceptions win over interrupts. Any trap wins over MRET.
- FSM states: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
  - RESET → OPERATING, unconditionally.
  - OPERATING → TRAP_TAKEN on `exc | irq`. Otherwise → TRAP_RETURN on MRET. Otherwise stays in OPERATING.
  - TRAP_TAKEN → OPERATING.
  - TRAP_RETURN → OPERATING.
- `cause_out` and `i_or_e_out` are registered on the OPERATING→TRAP_TAKEN edge and hold until the next trap. `misaligned_exception_out` is registered on the same edge.
- Outputs by state:
  - RESET: `pc_src = 00`, `flush = 1`, all other strobes 0.
  - OPERATING: `pc_src = 11`. `instret_inc = 1` when no trap and no MRET is requested this cycle. Other strobes 0.
  - TRAP_TAKEN: `pc_src = 10`. `trap_taken`, `flush`, `set_epc`, `set_cause` and `mie_clear` are all 1.
  - TRAP_RETURN: `pc_src = 01`. `flush` and `mie_set` are 1.

## Timing
- Reset (asynchronous assert, synchronous release): state = RESET, `pc_src = 00`, `flush = 1`. `cause_out`, `i_or_e_out`, `misaligned_exception_out` and every other strobe = 0.
- Reset asserted mid-trap aborts the trap immediately and issues no CSR strobes.
- A trap condition sampled in cycle N gives TRAP_TAKEN outputs in cycle N+1 (one cycle wide) and OPERATING in cycle N+2.
- MRET gives the same timing with TRAP_RETURN.
- Request inputs are ignored while in TRAP_TAKEN or TRAP_RETURN. The flushed instruction never re-triggers a trap.
- Consecutive traps are allowed: a trap condition in the first OPERATING cycle after TRAP_TAKEN traps again.
- `instret_inc_out` is never 1 in a cycle that requests a trap or MRET.

## Test plan
- Reset release → one RESET cycle (`pc_src = 00`, `flush = 1`), then `pc_src = 11` and `instret_inc = 1`. Async reset asserted mid-TRAP_TAKEN → all strobes 0 in the same cycle.
- `illegal_instr_in = 1` for one cycle → next cycle `trap_taken = 1`, `cause = 2`, `i_or_e = 0`, `pc_src = 10`, `mie_clear = 1`. The cycle after that, `pc_src = 11`.
- `misaligned_load_in` and `illegal_instr_in` together with `meip`/`meie`/`mie` = 1 → `cause = 2`, `i_or_e = 0`.
- Same case with only `misaligned_load_in` → `cause = 4`, `misaligned_exception = 1`.
- `mie = 1`, `msip = mtip = 1` with enables set, no exception → `cause = 3`, `i_or_e = 1`. Same pending bits with `mie = 0` → no trap and `instret_inc = 1`.
- MRET encoding (`0x30200073` fields) → next cycle `pc_src = 01`, `mie_set = 1`, `flush = 1`, `trap_taken = 0`.
- ECALL → `cause = 11`, `i_or_e = 0`. EBREAK → `cause = 3`, `i_or_e = 0`. WFI → no trap and `instret_inc = 1`.
